// File: rtl/oled_frame_streamer.sv
// Streams a page/column frame from a read/ack byte source out over OLED SPI pins.
// Define OLED_STREAM_TIMEOUT_EN to bound each ack wait to ACK_TIMEOUT cycles.
module oled_frame_streamer #(
  parameter int CLK_DIV     = 4,
  parameter int NUM_PAGES   = 8,
  parameter int NUM_COLUMNS = 128,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       timeout_err,
  output logic       read,
  output logic [5:0] row_idx,
  output logic [6:0] column_idx,
  input  logic [7:0] data,
  input  logic       ack,
  output logic       pin_din,
  output logic       pin_clk,
  output logic       pin_cs,
  output logic       pin_dc
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [5:0] ROW_LAST = 6'(NUM_PAGES - 1);
  localparam logic [6:0] COL_LAST = 7'(NUM_COLUMNS - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic          phase;
  logic [7:0]    shreg;
  logic          tick;
  logic          byte_end;
  logic          last_pos;
  logic          tmo;

  assign tick     = (div_cnt == DIV_LAST);
  assign byte_end = (state == SHIFT) && tick && phase
                    && (bit_cnt == 3'd7);
  assign last_pos = (row_idx == ROW_LAST)
                    && (column_idx == COL_LAST);

`ifdef OLED_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(ACK_TIMEOUT - 1);

  logic [TW-1:0] tmo_cnt;
  logic          err;

  // fires on the last allowed WAIT cycle; a same-cycle ack wins
  assign tmo = (state == WAIT) && !ack && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt <= '0;
      err     <= 1'b0;
    end else begin
      if (state != WAIT)
        tmo_cnt <= '0;
      else if (!tmo)
        tmo_cnt <= tmo_cnt + 1'b1;
      if (state == IDLE && start)
        err <= 1'b0;
      else if (tmo)
        err <= 1'b1;
    end
  end

  assign timeout_err = err;
`else
  assign tmo         = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    read      = 1'b0;
    pin_cs    = 1'b1;
    pin_dc    = 1'b0;
    pin_clk   = 1'b0;
    pin_din   = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nxt = REQ;
      end
      REQ: begin
        busy      = 1'b1;
        read      = 1'b1;
        pin_cs    = 1'b0;
        pin_dc    = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        pin_cs = 1'b0;
        pin_dc = 1'b1;
        if (ack || tmo)
          state_nxt = SHIFT;
      end
      SHIFT: begin
        busy    = 1'b1;
        pin_cs  = 1'b0;
        pin_dc  = 1'b1;
        pin_clk = phase;
        pin_din = shreg[7];
        if (byte_end)
          state_nxt = last_pos ? DONE : REQ;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_idx    <= '0;
      column_idx <= '0;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      phase      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            row_idx    <= '0;
            column_idx <= '0;
          end
        end
        WAIT: begin
          if (ack)
            shreg <= data;
          else if (tmo)
            shreg <= 8'h00;
        end
        SHIFT: begin
          if (!tick) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            phase   <= !phase;
            if (phase) begin
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
            end
            // column inner, page outer
            if (byte_end) begin
              if (column_idx == COL_LAST) begin
                column_idx <= '0;
                row_idx    <= (row_idx == ROW_LAST)
                              ? 6'd0 : row_idx + 6'd1;
              end else begin
                column_idx <= column_idx + 7'd1;
              end
            end
          end
        end
        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          phase   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_oled_frame_streamer.sv
// Directed bench: a default-size frame plus a 2x3 frame with scripted responders.
`timescale 1ns/1ps
module tb_oled_frame_streamer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int checks = 0;
  int fails = 0;

  // default-size instance
  logic start_b = 1'b0;
  logic busy_b, done_b, terr_b, read_b;
  logic din_b, sclk_b, cs_b, dc_b;
  logic [5:0] row_b;
  logic [6:0] col_b;
  logic [7:0] data_b = 8'h00;
  logic ack_b = 1'b0;

  // 2 pages x 3 columns instance
  logic start_s = 1'b0;
  logic busy_s, done_s, terr_s, read_s;
  logic din_s, sclk_s, cs_s, dc_s;
  logic [5:0] row_s;
  logic [6:0] col_s;
  logic [7:0] data_s = 8'h00;
  logic ack_s = 1'b0;

  oled_frame_streamer u_big (
    .clk(clk), .reset(reset), .start(start_b),
    .busy(busy_b), .done(done_b), .timeout_err(terr_b),
    .read(read_b), .row_idx(row_b), .column_idx(col_b),
    .data(data_b), .ack(ack_b), .pin_din(din_b),
    .pin_clk(sclk_b), .pin_cs(cs_b), .pin_dc(dc_b)
  );

  oled_frame_streamer #(
    .CLK_DIV(4), .NUM_PAGES(2), .NUM_COLUMNS(3), .ACK_TIMEOUT(15)
  ) u_small (
    .clk(clk), .reset(reset), .start(start_s),
    .busy(busy_s), .done(done_s), .timeout_err(terr_s),
    .read(read_s), .row_idx(row_s), .column_idx(col_s),
    .data(data_s), .ack(ack_s), .pin_din(din_s),
    .pin_clk(sclk_s), .pin_cs(cs_s), .pin_dc(dc_s)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // responder and capture state
  logic pend_b = 1'b0;
  logic [5:0] prow_b;
  logic [6:0] pcol_b;
  int nrd_b = 0, ndone_b = 0, nb_b = 0;
  logic [7:0] sh_b = 8'h00;
  logic pclk_b = 1'b0;
  logic [12:0] last_rq_b = '0;
  logic [7:0] by_b[$];

  int cnt_s = 0, lat_s = 1, mode_s = 0, ndone_s = 0, nb_s = 0;
  logic [7:0] val_s = 8'h00, byte_s = 8'h00, sh_s = 8'h00;
  logic pclk_s = 1'b0;
  logic [12:0] rq_s[$];
  logic [7:0] by_s[$];

  function automatic logic [7:0] cb_byte(input logic [5:0] r,
                                         input logic [6:0] c);
    if (c[3] ^ r[0])
      return 8'h00;
    return c[0] ? 8'hAA : 8'h55;
  endfunction

  // checkerboard responder, ack one cycle after read
  initial forever begin
    @(negedge clk);
    ack_b = 1'b0;
    data_b = 8'h00;
    if (pend_b) begin
      ack_b = 1'b1;
      data_b = cb_byte(prow_b, pcol_b);
      pend_b = 1'b0;
    end
    if (read_b) begin
      pend_b = 1'b1;
      prow_b = row_b;
      pcol_b = col_b;
    end
  end

  // scripted responder: lat_s cycles after read (0 = never)
  initial forever begin
    @(negedge clk);
    ack_s = 1'b0;
    data_s = 8'h00;
    if (cnt_s > 0) begin
      cnt_s--;
      if (cnt_s == 0) begin
        ack_s = 1'b1;
        data_s = byte_s;
      end
    end
    if (read_s && lat_s > 0) begin
      cnt_s = lat_s;
      byte_s = (mode_s == 0) ? {row_s[3:0], col_s[3:0]} : val_s;
    end
  end

  initial forever begin
    @(negedge clk);
    if (read_b) begin
      nrd_b++;
      last_rq_b = {row_b, col_b};
    end
    if (done_b) ndone_b++;
    if (sclk_b && !pclk_b) begin
      sh_b = {sh_b[6:0], din_b};
      nb_b++;
      if (nb_b == 8) begin
        by_b.push_back(sh_b);
        nb_b = 0;
      end
    end
    pclk_b = sclk_b;
  end

  initial forever begin
    @(negedge clk);
    if (read_s) rq_s.push_back({row_s, col_s});
    if (done_s) ndone_s++;
    if (sclk_s && !pclk_s) begin
      sh_s = {sh_s[6:0], din_s};
      nb_s++;
      if (nb_s == 8) begin
        by_s.push_back(sh_s);
        nb_s = 0;
      end
    end
    pclk_s = sclk_s;
  end

  task automatic clear_s();
    @(posedge clk);
    rq_s.delete();
    by_s.delete();
    nb_s = 0;
    ndone_s = 0;
    cnt_s = 0;
  endtask

  task automatic start_small();
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
  endtask

  task automatic abort_s();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] exp_v;
    logic [19:0] got_v;
    exp_v = {4'b0000, 6'd0, 7'd0, 4'b0010};
    @(negedge clk);
    got_v = {busy_s, done_s, terr_s, read_s, row_s, col_s,
             din_s, sclk_s, cs_s, dc_s};
    checks++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL reset_small: got %h expected %h", got_v, exp_v);
    end
    got_v = {busy_b, done_b, terr_b, read_b, row_b, col_b,
             din_b, sclk_b, cs_b, dc_b};
    checks++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL reset_big: got %h expected %h", got_v, exp_v);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    got_v = {busy_s, done_s, terr_s, read_s, row_s, col_s,
             din_s, sclk_s, cs_s, dc_s};
    checks++;
    if (got_v !== exp_v) begin
      fails++;
      $display("FAIL idle_after_reset: got %h expected %h", got_v, exp_v);
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] got8;
    mode_s = 1;
    val_s = 8'hAA;
    lat_s = 1;
    clear_s();
    start_small();
    checks++;
    if ({read_s, busy_s, cs_s, dc_s} !== 4'b1101) begin
      fails++;
      $display("FAIL start_outputs: got %b expected 1101",
               {read_s, busy_s, cs_s, dc_s});
    end
    for (int i = 0; i < 400 && !(col_s == 7'd1 && sclk_s); i++)
      @(negedge clk);
    checks++;
    if ({col_s, sclk_s} !== {7'd1, 1'b1}) begin
      fails++;
      $display("FAIL reach_second_shift: got %h expected %h",
               {col_s, sclk_s}, {7'd1, 1'b1});
    end
    got8 = (by_s.size() > 0) ? by_s[0] : 8'hxx;
    checks++;
    if (got8 !== 8'hAA) begin
      fails++;
      $display("FAIL byte_aa: got %h expected aa", got8);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cs_s, sclk_s, busy_s, read_s} !== 4'b1000) begin
      fails++;
      $display("FAIL async_abort: got %b expected 1000",
               {cs_s, sclk_s, busy_s, read_s});
    end
    @(negedge clk);
    reset = 1'b0;
    clear_s();
    start_small();
    checks++;
    if ({read_s, row_s, col_s} !== {1'b1, 6'd0, 7'd0}) begin
      fails++;
      $display("FAIL restart_origin: got %h expected %h",
               {read_s, row_s, col_s}, {1'b1, 6'd0, 7'd0});
    end
    abort_s();
  endtask

  task automatic test_frame_order();
    logic [12:0] exp_rq [6];
    logic [7:0] exp_by [6];
    logic [12:0] got13;
    logic [7:0] got8;
    exp_rq[0] = {6'd0, 7'd0};
    exp_rq[1] = {6'd0, 7'd1};
    exp_rq[2] = {6'd0, 7'd2};
    exp_rq[3] = {6'd1, 7'd0};
    exp_rq[4] = {6'd1, 7'd1};
    exp_rq[5] = {6'd1, 7'd2};
    exp_by[0] = 8'h00;
    exp_by[1] = 8'h01;
    exp_by[2] = 8'h02;
    exp_by[3] = 8'h10;
    exp_by[4] = 8'h11;
    exp_by[5] = 8'h12;
    mode_s = 0;
    lat_s = 1;
    clear_s();
    start_small();
    repeat (20) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    for (int i = 0; i < 600 && !done_s; i++)
      @(negedge clk);
    checks++;
    if ({done_s, busy_s, cs_s} !== 3'b101) begin
      fails++;
      $display("FAIL done_pulse: got %b expected 101",
               {done_s, busy_s, cs_s});
    end
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    checks++;
    if ({busy_s, read_s, done_s, cs_s} !== 4'b0001) begin
      fails++;
      $display("FAIL start_on_done: got %b expected 0001",
               {busy_s, read_s, done_s, cs_s});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (rq_s.size() !== 6) begin
      fails++;
      $display("FAIL read_count: got %0d expected 6", rq_s.size());
    end
    for (int k = 0; k < 6; k++) begin
      got13 = (k < rq_s.size()) ? rq_s[k] : 'x;
      checks++;
      if (got13 !== exp_rq[k]) begin
        fails++;
        $display("FAIL req_order[%0d]: got %h expected %h",
                 k, got13, exp_rq[k]);
      end
      got8 = (k < by_s.size()) ? by_s[k] : 8'hxx;
      checks++;
      if (got8 !== exp_by[k]) begin
        fails++;
        $display("FAIL shifted[%0d]: got %h expected %h",
                 k, got8, exp_by[k]);
      end
    end
    checks++;
    if (ndone_s !== 1) begin
      fails++;
      $display("FAIL done_count: got %0d expected 1", ndone_s);
    end
    checks++;
    if ({row_s, col_s} !== 13'd0) begin
      fails++;
      $display("FAIL idx_after_done: got %h expected 0",
               {row_s, col_s});
    end
  endtask

  task automatic test_slow_ack();
    logic [7:0] got8;
    mode_s = 1;
    val_s = 8'h81;
    lat_s = 5;
    clear_s();
    start_small();
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checks++;
      if ({read_s, row_s, col_s, sclk_s, busy_s}
          !== {1'b0, 6'd0, 7'd0, 1'b0, 1'b1}) begin
        fails++;
        $display("FAIL wait_hold[%0d]: got %h expected %h", k,
                 {read_s, row_s, col_s, sclk_s, busy_s},
                 {1'b0, 6'd0, 7'd0, 1'b0, 1'b1});
      end
    end
    @(negedge clk);
    checks++;
    if ({sclk_s, din_s} !== 2'b01) begin
      fails++;
      $display("FAIL first_bit: got %b expected 01", {sclk_s, din_s});
    end
    for (int i = 0; i < 200 && by_s.size() == 0; i++)
      @(negedge clk);
    got8 = (by_s.size() > 0) ? by_s[0] : 8'hxx;
    checks++;
    if (got8 !== 8'h81) begin
      fails++;
      $display("FAIL slow_byte: got %h expected 81", got8);
    end
    checks++;
    if (rq_s.size() !== 1) begin
      fails++;
      $display("FAIL single_read: got %0d expected 1", rq_s.size());
    end
    abort_s();
  endtask

  task automatic test_timeout();
    logic [7:0] got8;
    mode_s = 1;
    val_s = 8'h5A;
    lat_s = 0;
    clear_s();
    start_small();
`ifdef OLED_STREAM_TIMEOUT_EN
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      checks++;
      if ({terr_s, sclk_s, busy_s} !== 3'b001) begin
        fails++;
        $display("FAIL tmo_wait[%0d]: got %b expected 001",
                 k, {terr_s, sclk_s, busy_s});
      end
    end
    @(negedge clk);
    checks++;
    if ({terr_s, din_s, sclk_s} !== 3'b100) begin
      fails++;
      $display("FAIL tmo_fire: got %b expected 100",
               {terr_s, din_s, sclk_s});
    end
    for (int i = 0; i < 200 && by_s.size() == 0; i++)
      @(negedge clk);
    got8 = (by_s.size() > 0) ? by_s[0] : 8'hxx;
    checks++;
    if (got8 !== 8'h00) begin
      fails++;
      $display("FAIL tmo_byte: got %h expected 00", got8);
    end
    for (int i = 0; i < 700 && !done_s; i++)
      @(negedge clk);
    @(negedge clk);
    checks++;
    if ({terr_s, busy_s} !== 2'b10) begin
      fails++;
      $display("FAIL tmo_sticky: got %b expected 10", {terr_s, busy_s});
    end
    start_small();
    checks++;
    if ({terr_s, read_s} !== 2'b01) begin
      fails++;
      $display("FAIL tmo_clear: got %b expected 01", {terr_s, read_s});
    end
`else
    repeat (100) @(negedge clk);
    checks++;
    if ({busy_s, sclk_s, cs_s, terr_s} !== 4'b1000) begin
      fails++;
      $display("FAIL wait_forever: got %b expected 1000",
               {busy_s, sclk_s, cs_s, terr_s});
    end
    got8 = 8'(by_s.size());
    checks++;
    if (rq_s.size() !== 1 || got8 !== 8'd0) begin
      fails++;
      $display("FAIL wait_no_traffic: got reads %0d bytes %0d expected 1 0",
               rq_s.size(), got8);
    end
`endif
    abort_s();
  endtask

  task automatic test_checkerboard_frame();
    int rcyc;
    int dcyc;
    logic [7:0] got8;
    int idx [5];
    logic [7:0] exp8 [5];
    idx[0] = 0;    exp8[0] = 8'h55;
    idx[1] = 1;    exp8[1] = 8'hAA;
    idx[2] = 8;    exp8[2] = 8'h00;
    idx[3] = 128;  exp8[3] = 8'h00;
    idx[4] = 1023; exp8[4] = 8'hAA;
    @(posedge clk);
    by_b.delete();
    nrd_b = 0;
    ndone_b = 0;
    nb_b = 0;
    @(negedge clk);
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    rcyc = cyc;
    checks++;
    if ({read_b, busy_b} !== 2'b11) begin
      fails++;
      $display("FAIL big_start: got %b expected 11", {read_b, busy_b});
    end
    for (int i = 0; i < 70000 && !done_b; i++)
      @(negedge clk);
    dcyc = cyc;
    // the first read cycle counts as cycle 1
    checks++;
    if (dcyc - rcyc + 1 !== 67585) begin
      fails++;
      $display("FAIL frame_cycles: got %0d expected 67585",
               dcyc - rcyc + 1);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (nrd_b !== 1024 || by_b.size() !== 1024) begin
      fails++;
      $display("FAIL frame_counts: got reads %0d bytes %0d expected 1024",
               nrd_b, by_b.size());
    end
    for (int k = 0; k < 5; k++) begin
      got8 = (idx[k] < by_b.size()) ? by_b[idx[k]] : 8'hxx;
      checks++;
      if (got8 !== exp8[k]) begin
        fails++;
        $display("FAIL checker[%0d]: got %h expected %h",
                 idx[k], got8, exp8[k]);
      end
    end
    checks++;
    if (last_rq_b !== {6'd7, 7'd127}) begin
      fails++;
      $display("FAIL last_request: got %h expected %h",
               last_rq_b, {6'd7, 7'd127});
    end
    checks++;
    if ({ndone_b[3:0], busy_b, cs_b, sclk_b, row_b, col_b}
        !== {4'd1, 3'b010, 13'd0}) begin
      fails++;
      $display("FAIL frame_end: got %h expected %h",
               {ndone_b[3:0], busy_b, cs_b, sclk_b, row_b, col_b},
               {4'd1, 3'b010, 13'd0});
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_reset_mid_shift();
    test_frame_order();
    test_slow_ack();
    test_timeout();
    test_checkerboard_frame();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
